// File: rtl/wb_slave_regbank_if.sv
// Wishbone classic bus bundle between a master and the register-bank slave.
interface wb_slave_regbank_if #(
  parameter int unsigned g_data_width = 32,
  parameter int unsigned g_addr_width = 32
) ();
  logic [g_addr_width-1:0]   wb_adr_i;
  logic [g_data_width-1:0]   wb_dat_i;
  logic [g_data_width-1:0]   wb_dat_o;
  logic [g_data_width/8-1:0] wb_sel_i;
  logic                      wb_cyc_i;
  logic                      wb_stb_i;
  logic                      wb_we_i;
  logic                      wb_ack_o;
  logic                      wb_stall_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/wb_slave_regbank.sv
// Wishbone classic slave terminating single transfers into a register bank,
// with byte-lane writes, fixed wait states, cycle abort and a side read port.
module wb_slave_regbank #(
  parameter int unsigned               g_data_width  = 32,
  parameter int unsigned               g_addr_width  = 32,
  parameter int unsigned               g_num_regs    = 16,
  parameter int unsigned               g_wait_states = 0,
  parameter logic [g_data_width-1:0]   g_reset_value = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  wb_slave_regbank_if.slave             wb,
  output logic                          wr_o,
  output logic [$clog2(g_num_regs)-1:0] wr_idx_o,
  input  logic [$clog2(g_num_regs)-1:0] reg_idx_i,
  output logic [g_data_width-1:0]       reg_dat_o
);
  localparam int unsigned IDX_W = $clog2(g_num_regs);
  localparam int unsigned NSEL  = g_data_width / 8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [g_data_width-1:0] wdat_q, wdat_d;
  logic [NSEL-1:0]         sel_q, sel_d;
  logic                    we_q, we_d;
  logic [g_data_width-1:0] rdat_q, rdat_d;
  logic                    wr_q, wr_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic [g_data_width-1:0] regs_q [g_num_regs];
  logic [g_data_width-1:0] regs_d [g_num_regs];

  logic [IDX_W-1:0] adr_idx;
  assign adr_idx = wb.wb_adr_i[IDX_W-1:0];

  // Upper address bits only alias onto the bank.
  if (g_addr_width > IDX_W) begin : g_adr_hi
    logic unused_adr_hi;
    assign unused_adr_hi = ^wb.wb_adr_i[g_addr_width-1:IDX_W];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      wdat_q   <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      rdat_q   <= '0;
      wr_q     <= 1'b0;
      wr_idx_q <= '0;
      for (int unsigned i = 0; i < g_num_regs; i++) regs_q[i] <= g_reset_value;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdat_q   <= wdat_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      rdat_q   <= rdat_d;
      wr_q     <= wr_d;
      wr_idx_q <= wr_idx_d;
      regs_q   <= regs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    rdat_d   = rdat_q;
    wr_d     = 1'b0;
    wr_idx_d = wr_idx_q;
    regs_d   = regs_q;
    unique case (state_q)
      S_IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          idx_d  = adr_idx;
          wdat_d = wb.wb_dat_i;
          sel_d  = wb.wb_sel_i;
          we_d   = wb.wb_we_i;
          cnt_d  = 3'(g_wait_states);
          if (g_wait_states == 0) begin
            state_d = S_ACK;
            rdat_d  = regs_q[adr_idx];
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wb.wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd1) begin
          state_d = S_ACK;
          rdat_d  = regs_q[idx_q];
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (we_q && (sel_q != '0)) begin
          for (int unsigned i = 0; i < NSEL; i++)
            if (sel_q[i]) regs_d[idx_q][8*i +: 8] = wdat_q[8*i +: 8];
          wr_d     = 1'b1;
          wr_idx_d = idx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb.wb_ack_o   = 1'b0;
    wb.wb_stall_o = 1'b1;
    wb.wb_dat_o   = '0;
    unique case (state_q)
      S_IDLE:  wb.wb_stall_o = 1'b0;
      S_ACK: begin
        wb.wb_ack_o = 1'b1;
        wb.wb_dat_o = rdat_q;
      end
      default: ;
    endcase
  end

  assign wr_o      = wr_q;
  assign wr_idx_o  = wr_idx_q;
  assign reg_dat_o = regs_q[reg_idx_i];
endmodule
